// File: rtl/vid_sync_pkg.sv
// Shared types, helpers and default 640x480 timing for the video sync generator.
package vid_sync_pkg;

    localparam int unsigned CNT_W_DEFAULT = 11;

    typedef logic [CNT_W_DEFAULT-1:0] count_t;

    localparam int unsigned H_RES_DEFAULT  = 640;
    localparam int unsigned H_FP_DEFAULT   = 16;
    localparam int unsigned H_SYNC_DEFAULT = 96;
    localparam int unsigned H_BP_DEFAULT   = 48;
    localparam int unsigned V_RES_DEFAULT  = 480;
    localparam int unsigned V_FP_DEFAULT   = 10;
    localparam int unsigned V_SYNC_DEFAULT = 2;
    localparam int unsigned V_BP_DEFAULT   = 33;

    function automatic int unsigned timing_total(input int unsigned res, input int unsigned fp,
                                                 input int unsigned sync, input int unsigned bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vid_timing_axis.sv
// One raster axis: wrapping counter with terminal count, plus registered
// display-enable and sync decode taken from the next count value.
module vid_timing_axis
    import vid_sync_pkg::*;
#(
    parameter int unsigned Width = 11,
    parameter int unsigned Res   = 640,
    parameter int unsigned Fp    = 16,
    parameter int unsigned Sync  = 96,
    parameter int unsigned Bp    = 48,
    parameter bit          Pol   = 1'b0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o,
    output logic             tc_o,
    output logic             de_o,
    output logic             sync_o
);

    localparam int unsigned Total = timing_total(Res, Fp, Sync, Bp);

    // One extra bit so a region ending exactly at 2**Width still compares correctly.
    localparam logic [Width:0] Last      = (Width + 1)'(Total - 1);
    localparam logic [Width:0] DeEnd     = (Width + 1)'(Res);
    localparam logic [Width:0] SyncStart = (Width + 1)'(Res + Fp);
    localparam logic [Width:0] SyncEnd   = (Width + 1)'(Res + Fp + Sync);

    logic [Width-1:0] count_q, count_d;
    logic             de_q, de_d;
    logic             sync_q, sync_d;

    assign tc_o = ({1'b0, count_q} == Last);

    always_comb begin
        count_d = count_q;
        de_d    = de_q;
        sync_d  = sync_q;
        if (inc_i) begin
            count_d = tc_o ? '0 : count_q + Width'(1);
            de_d    = ({1'b0, count_d} < DeEnd);
            sync_d  = (({1'b0, count_d} >= SyncStart) && ({1'b0, count_d} < SyncEnd)) ? Pol : ~Pol;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= Last[Width-1:0];
            de_q    <= 1'b0;
            sync_q  <= ~Pol;
        end else begin
            count_q <= count_d;
            de_q    <= de_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o = count_q;
    assign de_o    = de_q;
    assign sync_o  = sync_q;

endmodule

// File: rtl/vid_sync_generator.sv
// Raster timing source: pixel-slot phase counter, H/V counters and registered sync decode.
// Optional per-line interrupt enabled by defining VID_SYNC_GENERATOR_LINE_IRQ_EN.
module vid_sync_generator
    import vid_sync_pkg::*;
#(
    parameter int unsigned PC_DIV = 4,
    parameter int unsigned CNT_W  = CNT_W_DEFAULT,
    parameter int unsigned H_RES  = H_RES_DEFAULT,
    parameter int unsigned H_FP   = H_FP_DEFAULT,
    parameter int unsigned H_SYNC = H_SYNC_DEFAULT,
    parameter int unsigned H_BP   = H_BP_DEFAULT,
    parameter int unsigned V_RES  = V_RES_DEFAULT,
    parameter int unsigned V_FP   = V_FP_DEFAULT,
    parameter int unsigned V_SYNC = V_SYNC_DEFAULT,
    parameter int unsigned V_BP   = V_BP_DEFAULT,
    parameter bit          HS_POL = 1'b0,
    parameter bit          VS_POL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef VID_SYNC_GENERATOR_LINE_IRQ_EN
    input  logic [CNT_W-1:0] irq_line,
    output logic             line_irq,
`endif
    output logic [3:0]       pc_ena,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hde,
    output logic             vde,
    output logic             hs,
    output logic             vs,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = timing_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_RES, V_FP, V_SYNC, V_BP);
    localparam logic [3:0]  PcLast  = 4'(PC_DIV - 1);

    if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : gen_h_total_err
        $error("H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : gen_v_total_err
        $error("V_TOTAL does not fit in CNT_W bits");
    end
    if (PC_DIV < 1 || PC_DIV > 16) begin : gen_pc_div_err
        $error("PC_DIV must be in 1..16");
    end

    logic [3:0] pc_q, pc_d;
    logic       advance;
    logic       h_tc, v_tc;
    logic       frame_start_q, frame_start_d;

    // With PC_DIV=1 PcLast is 0, so every clock is an advance edge.
    assign advance = (pc_q == PcLast);
    assign pc_d    = advance ? 4'd0 : pc_q + 4'd1;

    vid_timing_axis #(
        .Width (CNT_W),
        .Res   (H_RES),
        .Fp    (H_FP),
        .Sync  (H_SYNC),
        .Bp    (H_BP),
        .Pol   (HS_POL)
    ) u_h_axis (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (advance),
        .count_o (h_count),
        .tc_o    (h_tc),
        .de_o    (hde),
        .sync_o  (hs)
    );

    vid_timing_axis #(
        .Width (CNT_W),
        .Res   (V_RES),
        .Fp    (V_FP),
        .Sync  (V_SYNC),
        .Bp    (V_BP),
        .Pol   (VS_POL)
    ) u_v_axis (
        .clk_i   (clk),
        .reset_i (reset),
        .inc_i   (advance && h_tc),
        .count_o (v_count),
        .tc_o    (v_tc),
        .de_o    (vde),
        .sync_o  (vs)
    );

    assign frame_start_d = advance && h_tc && v_tc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= 4'd0;
            frame_start_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pc_ena      = pc_q;
    assign frame_start = frame_start_q;

`ifdef VID_SYNC_GENERATOR_LINE_IRQ_EN
    logic [CNT_W-1:0] v_next;
    logic             line_irq_q, line_irq_d;

    // v_next never reaches V_TOTAL, so out-of-range irq_line values cannot match.
    assign v_next     = v_tc ? '0 : v_count + CNT_W'(1);
    assign line_irq_d = advance && h_tc && (v_next == irq_line);

    always_ff @(posedge clk) begin
        if (reset) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= line_irq_d;
        end
    end

    assign line_irq = line_irq_q;
`endif

endmodule
